// File: rtl/codebreaker_search.sv
// Brute-force key-search controller: sweeps keys OFFSET, OFFSET+STRIDE, ... up to key_limit
// through an external decrypt engine and reports the first key whose plaintext is printable.
module codebreaker_search #(
    parameter int         KEY_WIDTH  = 24,
    parameter int         DATA_WIDTH = 128,
    parameter int         KEY_OFFSET = 0,
    parameter int         KEY_STRIDE = 1,
    parameter logic [7:0] PRINT_LO   = 8'h20,
    parameter logic [7:0] PRINT_HI   = 8'h7E
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  resume,
    input  logic [DATA_WIDTH-1:0] bytes_in,
    input  logic [KEY_WIDTH-1:0]  key_limit,
    output logic                  dec_start,
    output logic [KEY_WIDTH-1:0]  dec_key,
    output logic [DATA_WIDTH-1:0] dec_cipher,
    input  logic                  dec_done,
    input  logic [DATA_WIDTH-1:0] dec_bytes_out,
    output logic [KEY_WIDTH-1:0]  key,
    output logic [DATA_WIDTH-1:0] bytes_out,
    output logic                  done,
    output logic                  error,
    output logic                  busy,
    output logic [KEY_WIDTH:0]    keys_tried
);

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // IDLE      | no search running; start accepted
    // LAUNCH    | dec_start pulse for cur_key
    // WAIT      | waiting for dec_done from the engine
    // CHECK     | screen candidate plaintext for printable bytes
    // FOUND     | match reported; start or resume accepted
    // EXHAUSTED | range swept without a match; start accepted
    // ABORT     | stopped mid-decrypt; swallow the outstanding dec_done

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT      = 3'd2,
        S_CHECK     = 3'd3,
        S_FOUND     = 3'd4,
        S_EXHAUSTED = 3'd5,
        S_ABORT     = 3'd6
    } state_t;

    localparam int                   NBYTES   = DATA_WIDTH / 8;
    localparam logic [KEY_WIDTH:0]   STRIDE_X = (KEY_WIDTH + 1)'(KEY_STRIDE);
    localparam logic [KEY_WIDTH-1:0] OFFSET_K = KEY_WIDTH'(KEY_OFFSET);

    state_t state, next_state;

    logic [KEY_WIDTH-1:0]  cur_key;
    logic [DATA_WIDTH-1:0] cipher;
    logic [DATA_WIDTH-1:0] cand;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] bytes_out_q;
    logic                  done_q;
    logic                  error_q;
    logic [KEY_WIDTH:0]    keys_tried_q;

    logic                  cand_ok;
    logic [KEY_WIDTH:0]    next_key;
    logic                  next_oob;
    logic                  offset_oob;
    logic                  start_ok_state;
    logic                  start_acc;
    logic                  resume_acc;

    // Extra top bit catches wrap-around of the key counter past the key width.
    assign next_key   = {1'b0, cur_key} + STRIDE_X;
    assign next_oob   = next_key[KEY_WIDTH] || (next_key > {1'b0, key_limit});
    assign offset_oob = OFFSET_K > key_limit;

    assign start_ok_state = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED);
    assign start_acc      = start && !stop && start_ok_state;
    assign resume_acc     = (state == S_FOUND) && resume && !start && !stop;

    always_comb begin
        cand_ok = 1'b1;
        for (int i = 0; i < NBYTES; i++) begin
            if ((cand[i*8 +: 8] < PRINT_LO) || (cand[i*8 +: 8] > PRINT_HI)) begin
                cand_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_EXHAUSTED: begin
                if (stop) begin
                    next_state = S_IDLE;
                end else if (start) begin
                    next_state = offset_oob ? S_EXHAUSTED : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                next_state = stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // A stop coinciding with dec_done has nothing left to drain.
                if (stop) begin
                    next_state = dec_done ? S_IDLE : S_ABORT;
                end else if (dec_done) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (stop) begin
                    next_state = S_IDLE;
                end else if (cand_ok) begin
                    next_state = S_FOUND;
                end else begin
                    next_state = next_oob ? S_EXHAUSTED : S_LAUNCH;
                end
            end
            S_FOUND: begin
                if (stop) begin
                    next_state = S_IDLE;
                end else if (start) begin
                    next_state = offset_oob ? S_EXHAUSTED : S_LAUNCH;
                end else if (resume) begin
                    next_state = next_oob ? S_EXHAUSTED : S_LAUNCH;
                end
            end
            S_ABORT: begin
                if (dec_done) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        dec_start = 1'b0;
        busy      = 1'b0;
        unique case (state)
            S_LAUNCH: begin
                dec_start = 1'b1;
                busy      = 1'b1;
            end
            S_WAIT, S_CHECK, S_ABORT: busy = 1'b1;
            default: begin
                dec_start = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Later assignments in this block deliberately override earlier ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_key      <= '0;
            cipher       <= '0;
            cand         <= '0;
            key_q        <= '0;
            bytes_out_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            keys_tried_q <= '0;
        end else begin
            if ((state == S_WAIT) && dec_done && !stop) begin
                cand         <= dec_bytes_out;
                keys_tried_q <= keys_tried_q + (KEY_WIDTH + 1)'(1);
            end
            if (start_acc) begin
                cipher       <= bytes_in;
                cur_key      <= OFFSET_K;
                done_q       <= 1'b0;
                error_q      <= 1'b0;
                key_q        <= '0;
                bytes_out_q  <= '0;
                keys_tried_q <= '0;
            end
            if (resume_acc) begin
                done_q <= 1'b0;
                if (!next_oob) begin
                    cur_key <= next_key[KEY_WIDTH-1:0];
                end
            end
            if ((state == S_CHECK) && !stop) begin
                if (cand_ok) begin
                    key_q       <= cur_key;
                    bytes_out_q <= cand;
                    done_q      <= 1'b1;
                end else if (!next_oob) begin
                    cur_key <= next_key[KEY_WIDTH-1:0];
                end
            end
            if (next_state == S_EXHAUSTED) begin
                done_q  <= 1'b1;
                error_q <= 1'b1;
            end
            if (stop && (state != S_IDLE)) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
        end
    end

    assign dec_key    = cur_key;
    assign dec_cipher = cipher;
    assign key        = key_q;
    assign bytes_out  = bytes_out_q;
    assign done       = done_q;
    assign error      = error_q;
    assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_codebreaker_search.sv
// Bench for codebreaker_search: three instances (offset/stride variants) driven by a
// 4-cycle behavioural decrypt engine, checked against a key-sweep reference model.
module tb_codebreaker_search;

    localparam int L = 4;

    logic clk = 1'b0;
    logic reset_n;

    logic         start [3];
    logic         stop [3];
    logic         resume [3];
    logic [127:0] bytes_in [3];
    logic [23:0]  key_limit [3];
    logic         dec_start [3];
    logic [23:0]  dec_key [3];
    logic [127:0] dec_cipher [3];
    logic         dec_done [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] dec_bytes_out [3] = '{128'h0, 128'h0, 128'h0};
    logic [23:0]  key [3];
    logic [127:0] bytes_out [3];
    logic         done [3];
    logic         error [3];
    logic         busy [3];
    logic [24:0]  keys_tried [3];

    int OFF [3] = '{0, 1, 0};
    int STR [3] = '{1, 2, 2};

    logic [127:0] plain [int];
    int           tried_q [$];
    int           vectors = 0;
    int           miscompares = 0;

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        codebreaker_search #(
            .KEY_OFFSET (g == 1 ? 1 : 0),
            .KEY_STRIDE (g == 0 ? 1 : 2)
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (start[g]),
            .stop          (stop[g]),
            .resume        (resume[g]),
            .bytes_in      (bytes_in[g]),
            .key_limit     (key_limit[g]),
            .dec_start     (dec_start[g]),
            .dec_key       (dec_key[g]),
            .dec_cipher    (dec_cipher[g]),
            .dec_done      (dec_done[g]),
            .dec_bytes_out (dec_bytes_out[g]),
            .key           (key[g]),
            .bytes_out     (bytes_out[g]),
            .done          (done[g]),
            .error         (error[g]),
            .busy          (busy[g]),
            .keys_tried    (keys_tried[g])
        );
    end

    function automatic logic [127:0] rand_printable();
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'($urandom_range(32, 126));
        return v;
    endfunction

    // Printable except one byte just outside (or far outside) the accepted range.
    function automatic logic [127:0] noise();
        logic [127:0] v;
        int           idx;
        logic [7:0]   b;
        v   = rand_printable();
        idx = $urandom_range(0, 15);
        case ($urandom_range(0, 3))
            0:       b = 8'h1F;
            1:       b = 8'h7F;
            2:       b = 8'($urandom_range(0, 31));
            default: b = 8'($urandom_range(128, 255));
        endcase
        v[idx*8 +: 8] = b;
        return v;
    endfunction

    // Engine: dec_done arrives L cycles after the dec_start cycle.
    int          eng_cnt [3] = '{0, 0, 0};
    logic [23:0] eng_key [3];
    always @(posedge clk) begin
        logic        ds [3];
        logic [23:0] dk [3];
        for (int i = 0; i < 3; i++) begin
            ds[i] = dec_start[i];
            dk[i] = dec_key[i];
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            dec_done[i] = 1'b0;
            if (!reset_n) begin
                eng_cnt[i] = 0;
            end else begin
                if (eng_cnt[i] > 0) begin
                    eng_cnt[i]--;
                    if (eng_cnt[i] == 0) begin
                        dec_done[i] = 1'b1;
                        if (plain.exists(int'(eng_key[i]))) dec_bytes_out[i] = plain[int'(eng_key[i])];
                        else dec_bytes_out[i] = noise();
                    end
                end
                if (ds[i] === 1'b1) begin
                    eng_cnt[i] = L - 1;
                    eng_key[i] = dk[i];
                end
            end
        end
    end

    // Reference: walk the arithmetic key sequence until a printable key or the range ends.
    function automatic void model(input int first, input int stride, input int limit,
                                  output bit found, output int mkey, output int tries);
        longint k = first;
        found = 0;
        mkey  = 0;
        tries = 0;
        while (k <= limit && k < (64'd1 << 24)) begin
            tries++;
            if (plain.exists(int'(k))) begin
                found = 1;
                mkey  = int'(k);
                return;
            end
            k += stride;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_wait(input int i, output int cycles, output int pulses);
        cycles = 0;
        pulses = 0;
        tried_q.delete();
        while (done[i] !== 1'b1 && cycles < 400) begin
            if (dec_start[i] === 1'b1) begin
                pulses++;
                tried_q.push_back(int'(dec_key[i]));
            end
            tick();
            cycles++;
        end
    endtask

    task automatic search_check(input int i, input logic [127:0] ct, input logic [23:0] limit,
                                input string tag);
        bit           found;
        int           mkey, tries, cycles, pulses;
        logic [127:0] exp_bytes;
        model(OFF[i], STR[i], int'(limit), found, mkey, tries);
        exp_bytes = '0;
        if (found) exp_bytes = plain[mkey];
        bytes_in[i]  = ct;
        key_limit[i] = limit;
        start[i]     = 1'b1;
        tick();
        start[i]     = 1'b0;
        if (tries > 0) chk({tag, "_done_clr"}, done[i], 0);
        run_wait(i, cycles, pulses);
        chk({tag, "_done"}, done[i], 1);
        chk({tag, "_error"}, error[i], !found);
        chk({tag, "_key"}, key[i], found ? mkey : 0);
        chk({tag, "_bytes_out"}, bytes_out[i], exp_bytes);
        chk({tag, "_keys_tried"}, keys_tried[i], tries);
        chk({tag, "_cycles"}, cycles, tries * (L + 2));
        chk({tag, "_pulses"}, pulses, tries);
        chk({tag, "_dec_cipher"}, dec_cipher[i], ct);
        for (int j = 0; j < tried_q.size(); j++)
            chk({tag, "_seq"}, tried_q[j], OFF[i] + j * STR[i]);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_done"}, done[0], 0);
        chk({tag, "_error"}, error[0], 0);
        chk({tag, "_busy"}, busy[0], 0);
        chk({tag, "_key"}, key[0], 0);
        chk({tag, "_bytes_out"}, bytes_out[0], 0);
        chk({tag, "_keys_tried"}, keys_tried[0], 0);
        chk({tag, "_dec_start"}, dec_start[0], 0);
        chk({tag, "_dec_key"}, dec_key[0], 0);
        chk({tag, "_dec_cipher"}, dec_cipher[0], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct0, p5, p9;
        bit           found;
        int           mkey, tries, tries1, cycles, pulses, k, done_seen;

        ct0 = 128'hca7d05cd7e096d91acaf6fd347ef4994;
        p5  = 128'h52205520484156494e472046554e2020;
        p9  = rand_printable();
        p9[7:0]  = 8'h20;
        p9[15:8] = 8'h7E;

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; stop[i] = 1'b0; resume[i] = 1'b0;
            bytes_in[i] = '0; key_limit[i] = '0;
        end
        tick(); tick(); tick();
        reset_check("reset");
        reset_n = 1'b1;
        tick();

        // Single printable key at 5.
        plain[5] = p5;
        search_check(0, ct0, 24'hFFFFFF, "s1");

        // No printable key in range.
        plain.delete();
        search_check(0, {$urandom, $urandom, $urandom, $urandom}, 24'h10, "s2");

        // Keys 5 and 9 printable, resume after the first hit.
        plain[5] = p5;
        plain[9] = p9;
        search_check(0, ct0, 24'hFFFFFF, "s3a");
        model(0, 1, 24'hFFFFFF, found, mkey, tries1);
        resume[0] = 1'b1;
        tick();
        resume[0] = 1'b0;
        chk("s3_done_fall", done[0], 0);
        chk("s3_busy", busy[0], 1);
        chk("s3_key_held", key[0], mkey);
        model(mkey + 1, 1, 24'hFFFFFF, found, mkey, tries);
        run_wait(0, cycles, pulses);
        chk("s3_key2", key[0], mkey);
        chk("s3_bytes2", bytes_out[0], plain[mkey]);
        chk("s3_keys_tried2", keys_tried[0], tries1 + tries);
        chk("s3_cycles2", cycles, tries * (L + 2));

        // Stride 2 variants.
        search_check(1, ct0, 24'hFFFFFF, "s4_off1");
        search_check(2, ct0, 24'h000008, "s4_off0");
        search_check(1, ct0, 24'h000000, "s4_offset_oob");

        // Stop during WAIT: ABORT drains the outstanding dec_done.
        bytes_in[0] = ct0; key_limit[0] = 24'hFFFFFF; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick(); tick();
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        chk("s5_busy_abort", busy[0], 1);
        k = 0; done_seen = -1;
        while (busy[0] === 1'b1 && k < 20) begin
            if (dec_done[0] === 1'b1) done_seen = k;
            tick();
            k++;
        end
        chk("s5_idle_after_done", k, done_seen + 1);
        chk("s5_done", done[0], 0);
        chk("s5_error", error[0], 0);
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            if (dec_start[0] === 1'b1) pulses++;
            tick();
        end
        chk("s5_no_launch", pulses, 0);

        // stop and start together in FOUND.
        search_check(0, ct0, 24'hFFFFFF, "s5b");
        stop[0] = 1'b1; start[0] = 1'b1;
        tick();
        stop[0] = 1'b0; start[0] = 1'b0;
        chk("s5b_busy", busy[0], 0);
        chk("s5b_done", done[0], 0);
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            if (dec_start[0] === 1'b1) pulses++;
            tick();
        end
        chk("s5b_no_launch", pulses, 0);

        // Reset mid-WAIT after a resume, while key/bytes_out/keys_tried are non-zero.
        search_check(0, ct0, 24'hFFFFFF, "s6a");
        resume[0] = 1'b1;
        tick();
        resume[0] = 1'b0;
        tick(); tick();
        #1 reset_n = 1'b0;
        #1 reset_check("s6_reset");
        tick(); tick();
        reset_n = 1'b1;
        tick();
        search_check(0, ct0, 24'hFFFFFF, "s6b");

        // Randomised ranges, printable sets and instances.
        for (int r = 0; r < 8; r++) begin
            int inst;
            plain.delete();
            for (int kk = 0; kk <= 24; kk++)
                if ($urandom_range(0, 7) == 0) plain[kk] = rand_printable();
            inst = $urandom_range(0, 2);
            search_check(inst, {$urandom, $urandom, $urandom, $urandom},
                         24'($urandom_range(0, 24)), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/codebreaker_search.md
# codebreaker_search

Parametrised brute-force key-search controller, next generation of the lab codebreaker. It sweeps a key range (offset, stride, limit) through an external decrypt engine over a start/done handshake and screens each candidate plaintext for printable ASCII. On a hit it reports the key and plaintext, and can resume to find further matches. Offset/stride let N instances partition one keyspace; `stop` aborts cleanly without orphaning an in-flight decryption.

## Interface
- `KEY_WIDTH`, 24: key width in bits.
- `DATA_WIDTH`, 128: block width in bits; must be a multiple of 8.
- `KEY_OFFSET`, 0: first key tried.
- `KEY_STRIDE`, 1: key increment; must be ≥1.
- `PRINT_LO`, 8'h20: lowest byte value accepted as printable.
- `PRINT_HI`, 8'h7E: highest byte value accepted as printable.

- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new search; level, sampled only in IDLE, FOUND, EXHAUSTED.
- `stop` in 1: abort the current search.
- `resume` in 1: in FOUND, continue from the next key.
- `bytes_in` in DATA_WIDTH: ciphertext; latched on accepted `start`.
- `key_limit` in KEY_WIDTH: last key allowed (inclusive); sampled continuously.
- `dec_start` out 1: one-cycle request to the decrypt engine.
- `dec_key` out KEY_WIDTH: key for the request; stable from `dec_start` until `dec_done`.
- `dec_cipher` out DATA_WIDTH: latched ciphertext.
- `dec_done` in 1: one-cycle completion pulse from the engine.
- `dec_bytes_out` in DATA_WIDTH: engine result; valid with `dec_done`.
- `key` out KEY_WIDTH: matching key.
- `bytes_out` out DATA_WIDTH: matching plaintext.
- `done` out 1: search ended (match or exhausted).
- `error` out 1: keyspace exhausted, no match.
- `busy` out 1: asserted in any state except IDLE, FOUND, EXHAUSTED.
- `keys_tried` out KEY_WIDTH+1: count of completed decryptions since last accepted `start`.

## Operation
- States: IDLE, LAUNCH, WAIT, CHECK, FOUND, EXHAUSTED, ABORT.
- Start:
  - Accepted `start` latches `bytes_in`, sets `cur_key = KEY_OFFSET`, and clears `done`, `error`, `key`, `bytes_out` and `keys_tried`.
  - Next state is LAUNCH, or EXHAUSTED if `KEY_OFFSET > key_limit`. In the EXHAUSTED case no `dec_start` is issued.
- LAUNCH: `dec_start=1` for exactly this cycle; next state WAIT.
- WAIT: on `dec_done`, capture `dec_bytes_out` into the candidate register, increment `keys_tried`, go to CHECK.
- CHECK: a match requires every byte b of the candidate to satisfy `PRINT_LO ≤ b ≤ PRINT_HI`.
  - Match: `key <= cur_key`, `bytes_out <= candidate`, `done=1`, go to FOUND.
  - Else compute `next = cur_key + KEY_STRIDE` in KEY_WIDTH+1 bits. If `next > key_limit` or bit KEY_WIDTH is set, go to EXHAUSTED. Otherwise `cur_key <= next` and go to LAUNCH.
- EXHAUSTED: `done=1`, `error=1`; `key` and `bytes_out` stay 0.
- FOUND with `resume`: `done` clears and the `next` rule applies. Out of range goes to EXHAUSTED; otherwise go to LAUNCH with `key`/`bytes_out` holding the previous match until replaced.
- Simultaneous `start` and `resume` in FOUND: `start` wins.
- `stop`:
  - In LAUNCH or CHECK: go to IDLE.
  - In WAIT: go to ABORT, which holds `busy=1` until `dec_done` and discards the result, then goes to IDLE.
  - In FOUND or EXHAUSTED: go to IDLE.
  - Entering IDLE via `stop` clears `done` and `error`.
  - `stop` beats `start`/`resume` in the same cycle.
- `dec_done` outside WAIT/ABORT is ignored.

## Timing
- `reset_n` low asynchronously forces IDLE. Every output is 0 while reset is asserted, and the internal registers are cleared.
- Accepted `start` at edge N: `dec_start` is high in cycle N+1.
- Per key: 1 (LAUNCH) + L (engine latency, `dec_done` ≥1 cycle after `dec_start`) + 1 (CHECK) cycles, so L+2.
- `done` rises the cycle after CHECK and is registered. `key` and `bytes_out` are valid no later than `done`.
- `done` falls the cycle after an accepted `start`, `resume` or `stop`.

## Test plan
Benches use a behavioural engine model with latency 4 cycles that returns non-printable output except for listed keys.
- Default params, `key_limit=24'hFFFFFF`, ciphertext 128'hca7d05cd7e096d91acaf6fd347ef4994, key 5 maps to 128'h52205520484156494e472046554e2020 -> `done=1`, `error=0`, `key=24'h000005`, `bytes_out` equal to that value, `keys_tried=6`, exactly 6 `dec_start` pulses, 36 cycles from `start` to `done`.
- No printable key, `key_limit=24'h10` -> `done=1`, `error=1`, `keys_tried=17`, `key=0`, `bytes_out=0`.
- Keys 5 and 9 printable -> first `key=5`. Pulse `resume` -> `done` low next cycle, then `key=9`, `keys_tried=10`.
- `KEY_STRIDE=2`, `KEY_OFFSET=1` -> keys tried are 1, 3, 5; `key=5`, `keys_tried=3`. With `KEY_OFFSET=0` and `key_limit=8` -> `error=1` after 5 tries.
- `stop` during WAIT -> `busy` stays high until `dec_done`, then IDLE with `done=0`; no further `dec_start`. Then `stop` and `start` in the same cycle in FOUND -> IDLE.
- `reset_n` low mid-WAIT -> all outputs 0 immediately. After release, a new `start` finds key 5 as in the first scenario.
